// File: rtl/ps2_mouse_packet_rx_if.sv
// Raw PS/2 lines plus the decoded mouse packet outputs of ps2_mouse_packet_rx.
// The master modport is the receiver; the slave modport is the mouse/consumer side.
interface ps2_mouse_packet_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       btn_left;
    logic       btn_right;
    logic       btn_middle;
    logic [8:0] x_delta;
    logic [8:0] y_delta;
    logic       x_ovf;
    logic       y_ovf;
    logic       packet_valid;
    logic       frame_err;
    logic       sync_err;
    logic       rx_busy;

    modport master (
        input  ps2_clk, ps2_data,
        output btn_left, btn_right, btn_middle, x_delta, y_delta,
               x_ovf, y_ovf, packet_valid, frame_err, sync_err, rx_busy
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  btn_left, btn_right, btn_middle, x_delta, y_delta,
               x_ovf, y_ovf, packet_valid, frame_err, sync_err, rx_busy
    );
endinterface

// File: rtl/ps2_mouse_packet_rx.sv
// Receive-only PS/2 mouse front end: filters the device clock, deframes 11-bit
// frames and assembles 3-byte standard mouse packets into held output registers.
module ps2_mouse_packet_rx #(
    parameter int CLK_FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_mouse_packet_rx_if.master bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    frame_state_t              state, state_nxt;
    logic                      ps2_clk_meta, ps2_clk_sync;
    logic                      ps2_data_meta, ps2_data_sync;
    logic [CLK_FILTER_LEN-1:0] clk_shift;
    logic                      clk_filt;
    logic                      fall_tick;
    logic [2:0]                bit_cnt, bit_cnt_nxt;
    logic [7:0]                sh, sh_nxt;
    logic                      parity_bit, parity_nxt;
    logic [1:0]                byte_idx;
    logic [7:0]                byte0, byte1;
    logic [TW-1:0]             tcnt;
    logic                      byte_done, stop_bad, timeout_hit, busy;

    // The filtered clock only moves once the whole shift window agrees.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_meta  <= 1'b1;
            ps2_clk_sync  <= 1'b1;
            ps2_data_meta <= 1'b1;
            ps2_data_sync <= 1'b1;
            clk_shift     <= '1;
            clk_filt      <= 1'b1;
        end else begin
            ps2_clk_meta  <= bus.ps2_clk;
            ps2_clk_sync  <= ps2_clk_meta;
            ps2_data_meta <= bus.ps2_data;
            ps2_data_sync <= ps2_data_meta;
            clk_shift     <= {clk_shift[CLK_FILTER_LEN-2:0], ps2_clk_sync};
            if (&clk_shift)
                clk_filt <= 1'b1;
            else if (~|clk_shift)
                clk_filt <= 1'b0;
        end
    end

    assign fall_tick   = clk_filt && (clk_shift == '0);
    assign busy        = (state != IDLE) || (byte_idx != 2'd0);
    assign timeout_hit = busy && !fall_tick && (tcnt == T_MAX);
    assign bus.rx_busy = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            sh         <= 8'd0;
            parity_bit <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sh         <= sh_nxt;
            parity_bit <= parity_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        sh_nxt      = sh;
        parity_nxt  = parity_bit;
        byte_done   = 1'b0;
        stop_bad    = 1'b0;
        if (fall_tick) begin
            case (state)
                IDLE: begin
                    if (!ps2_data_sync) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    sh_nxt      = {ps2_data_sync, sh[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
                PARITY: begin
                    parity_nxt = ps2_data_sync;
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (ps2_data_sync && (^{sh, parity_bit}))
                        byte_done = 1'b1;
                    else
                        stop_bad = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_nxt = IDLE;
        end
    end

    // Any clock edge restarts the idle window; it only runs while a frame or packet is open.
    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if (fall_tick || !busy || timeout_hit)
            tcnt <= '0;
        else if (tcnt != T_MAX)
            tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx         <= 2'd0;
            byte0            <= 8'd0;
            byte1            <= 8'd0;
            bus.btn_left     <= 1'b0;
            bus.btn_right    <= 1'b0;
            bus.btn_middle   <= 1'b0;
            bus.x_delta      <= 9'd0;
            bus.y_delta      <= 9'd0;
            bus.x_ovf        <= 1'b0;
            bus.y_ovf        <= 1'b0;
            bus.packet_valid <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.sync_err     <= 1'b0;
        end else begin
            bus.packet_valid <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.sync_err     <= 1'b0;
            if (stop_bad || timeout_hit) begin
                bus.frame_err <= 1'b1;
                byte_idx      <= 2'd0;
            end else if (byte_done) begin
                case (byte_idx)
                    2'd0: begin
                        // Bit 3 of the status byte is always set; anything else means we are misaligned.
                        if (sh[3]) begin
                            byte0    <= sh;
                            byte_idx <= 2'd1;
                        end else begin
                            bus.sync_err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        byte1    <= sh;
                        byte_idx <= 2'd2;
                    end
                    default: begin
                        byte_idx         <= 2'd0;
                        bus.btn_left     <= byte0[0];
                        bus.btn_right    <= byte0[1];
                        bus.btn_middle   <= byte0[2];
                        bus.x_delta      <= {byte0[4], byte1};
                        bus.y_delta      <= {byte0[5], sh};
                        bus.x_ovf        <= byte0[6];
                        bus.y_ovf        <= byte0[7];
                        bus.packet_valid <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Scoreboard bench for ps2_mouse_packet_rx: drives PS/2 frames on the raw lines and
// checks decoded packets, error pulses, timeout abort, clock glitch rejection and reset.
module tb_ps2_mouse_packet_rx;
    localparam int CLK_FILTER_LEN = 8;
    localparam int TIMEOUT_CYCLES = 2000;

    typedef struct {
        logic [22:0] outs;
        int          exp_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          frame_err_cnt = 0;
    int          sync_err_cnt = 0;
    int          last_ferr_cyc = 0;
    int          last_stop_cyc = 0;
    logic [22:0] last_outs = '0;
    logic [22:0] pending_outs = '0;
    exp_t        sb[$];

    ps2_mouse_packet_rx_if bus();

    ps2_mouse_packet_rx #(
        .CLK_FILTER_LEN(CLK_FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Packed order: left, right, middle, x_ovf, y_ovf, x_delta, y_delta
    function automatic logic [22:0] modelPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        return {b0[0], b0[1], b0[2], b0[6], b0[7], b0[4], b1, b0[5], b2};
    endfunction

    function automatic logic [22:0] packOut();
        return {bus.btn_left, bus.btn_right, bus.btn_middle, bus.x_ovf, bus.y_ovf, bus.x_delta, bus.y_delta};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.frame_err || bus.sync_err)
                checkOutput("err_exclusive", {31'd0, bus.frame_err & bus.sync_err}, 32'd0);
            if (bus.frame_err) begin
                frame_err_cnt++;
                last_ferr_cyc = cyc;
            end
            if (bus.sync_err)
                sync_err_cnt++;
            if (bus.packet_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_packet", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("packet_fields", {9'd0, packOut()}, {9'd0, e.outs});
                    checkOutput("packet_latency", cyc, e.exp_cyc);
                    last_outs = e.outs;
                end
            end
        end
    end

    // n_bits limits how many of the 11 frame bits go out, for truncated frames.
    task automatic sendFrame(input logic [7:0] b, input bit bad_par, input int glitch_bit,
                             input int n_bits, input bit push);
        logic [10:0] bits;
        exp_t        e;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (20) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i == 10) begin
                last_stop_cyc = cyc;
                if (push) begin
                    e.outs    = pending_outs;
                    e.exp_cyc = cyc + 3 + CLK_FILTER_LEN;
                    sb.push_back(e);
                end
            end
            repeat (30) @(negedge clk);
            bus.ps2_clk = 1'b1;
            if (glitch_bit >= 0 && i - 1 == glitch_bit) begin
                repeat (15) @(negedge clk);
                bus.ps2_clk = 1'b0;
                repeat (CLK_FILTER_LEN - 1) @(negedge clk);
                bus.ps2_clk = 1'b1;
            end
        end
        bus.ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                 input int glitch_bit);
        pending_outs = modelPacket(b0, b1, b2);
        sendFrame(b0, 1'b0, glitch_bit, 11, 1'b0);
        sendFrame(b1, 1'b0, -1, 11, 1'b0);
        sendFrame(b2, 1'b0, -1, 11, 1'b1);
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drain"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin : watchdog
        repeat (60000) @(negedge clk);
        errors++;
        $display("[TB] FAIL watchdog: got cycle %0d, want finish earlier", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int fe0;
        int se0;
        int diff;
        int lat;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs", {9'd0, packOut()}, 32'd0);
        checkOutput("reset_flags", {28'd0, bus.packet_valid, bus.frame_err, bus.sync_err, bus.rx_busy}, 32'd0);

        $display("[TB] basic packet");
        applyStimulus(8'h29, 8'h05, 8'hFB, -1);
        waitDrain("basic");
        checkOutput("basic_buttons", {29'd0, bus.btn_left, bus.btn_right, bus.btn_middle}, 32'h4);
        checkOutput("basic_x", bus.x_delta, 32'h005);
        checkOutput("basic_y", bus.y_delta, 32'h1FB);
        checkOutput("basic_ovf", {30'd0, bus.x_ovf, bus.y_ovf}, 32'd0);

        $display("[TB] parity error on byte1");
        fe0 = frame_err_cnt;
        sendFrame(8'h29, 1'b0, -1, 11, 1'b0);
        sendFrame(8'h05, 1'b1, -1, 11, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("parity_frame_err", frame_err_cnt - fe0, 32'd1);
        checkOutput("parity_hold", {9'd0, packOut()}, {9'd0, last_outs});
        checkOutput("parity_busy", {31'd0, bus.rx_busy}, 32'd0);
        applyStimulus(8'h0A, 8'h00, 8'h00, -1);
        waitDrain("right");
        checkOutput("right_buttons", {29'd0, bus.btn_left, bus.btn_right, bus.btn_middle}, 32'h2);
        checkOutput("right_xy", {bus.x_delta, bus.y_delta}, 32'd0);

        $display("[TB] sync error");
        se0 = sync_err_cnt;
        sendFrame(8'h01, 1'b0, -1, 11, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("sync_err_cnt", sync_err_cnt - se0, 32'd1);
        checkOutput("sync_busy", {31'd0, bus.rx_busy}, 32'd0);
        checkOutput("sync_hold", {9'd0, packOut()}, {9'd0, last_outs});
        applyStimulus(8'h0C, 8'hFF, 8'h01, -1);
        waitDrain("middle");
        checkOutput("middle_buttons", {29'd0, bus.btn_left, bus.btn_right, bus.btn_middle}, 32'h1);
        checkOutput("middle_x", bus.x_delta, 32'h0FF);
        checkOutput("middle_y", bus.y_delta, 32'h001);

        $display("[TB] timeout");
        fe0 = frame_err_cnt;
        sendFrame(8'h08, 1'b0, -1, 11, 1'b0);
        repeat (3000) @(negedge clk);
        checkOutput("timeout_frame_err", frame_err_cnt - fe0, 32'd1);
        checkOutput("timeout_busy", {31'd0, bus.rx_busy}, 32'd0);
        lat  = 3 + CLK_FILTER_LEN + TIMEOUT_CYCLES;
        diff = last_ferr_cyc - last_stop_cyc;
        checkOutput("timeout_latency", (diff >= lat - 1 && diff <= lat + 1) ? lat : diff, lat);
        checkOutput("timeout_hold", {9'd0, packOut()}, {9'd0, last_outs});
        applyStimulus(8'h08, 8'h01, 8'h02, -1);
        waitDrain("after_timeout");
        checkOutput("after_timeout_xy", {bus.x_delta, bus.y_delta}, {14'd0, 9'h001, 9'h002});

        $display("[TB] clock glitch");
        fe0 = frame_err_cnt;
        applyStimulus(8'h39, 8'h7F, 8'h80, 3);
        waitDrain("glitch");
        checkOutput("glitch_x", bus.x_delta, 32'h17F);
        checkOutput("glitch_y", bus.y_delta, 32'h180);
        checkOutput("glitch_no_err", frame_err_cnt - fe0, 32'd0);

        $display("[TB] reset mid-frame");
        sendFrame(8'hC9, 1'b0, -1, 5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_outputs", {9'd0, packOut()}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus.rx_busy}, 32'd0);
        applyStimulus(8'hC9, 8'h10, 8'h20, -1);
        waitDrain("after_rst");
        checkOutput("after_rst_ovf", {30'd0, bus.x_ovf, bus.y_ovf}, 32'h3);
        checkOutput("after_rst_left", {31'd0, bus.btn_left}, 32'd1);
        checkOutput("after_rst_xy", {bus.x_delta, bus.y_delta}, {14'd0, 9'h010, 9'h020});

        repeat (20) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
